// File: rtl/stream_selector_pkg.sv
// Shared types and parameter limits for the stream selector.
// Imported by the selector top, its interface and the arbiter.
package selector_pkg;

  typedef enum logic {
    FIXED       = 1'b0,
    ROUND_ROBIN = 1'b1
  } sel_mode_t;

  localparam int NUM_CH_MIN = 2;
  localparam int NUM_CH_MAX = 16;
  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;

  function automatic bit params_ok(
    input int num_ch,
    input int width
  );
    return num_ch >= NUM_CH_MIN &&
           num_ch <= NUM_CH_MAX &&
           width  >= WIDTH_MIN  &&
           width  <= WIDTH_MAX;
  endfunction

endpackage

// File: rtl/stream_selector_if.sv
// Input/output stream handshake bundle of the selector.
// slave = the selector, master = the environment around it.
interface stream_selector_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  localparam int SEL_W = $clog2(NUM_CH)
) ();

  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0][WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_ready;
  logic                         out_valid;
  logic [WIDTH-1:0]             out_data;
  logic [SEL_W-1:0]             out_ch;
  logic                         out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ch,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ch,
    output out_ready
  );

endinterface

// File: rtl/stream_selector_rr_arbiter.sv
// Round-robin grant: first requester above last_i, wrapping.
// Purely combinational; the caller owns the last-index state.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  last_i,
  output logic [IDX_W-1:0]  gnt_idx_o,
  output logic              gnt_vld_o
);

  always_comb begin
    int idx;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    // Scan farthest first so the nearest requester wins last.
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(last_i) + k) % NUM_CH;
      if (req_i[idx]) begin
        gnt_idx_o = IDX_W'(idx);
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_selector.sv
// N-to-1 stream selector with fixed or round-robin channel choice
// and a single registered output stage.
module stream_selector
  import selector_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 16,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  sel_mode_t            mode,
  input  logic [SEL_W-1:0]     sel,
  stream_selector_if.slave     bus,
  output logic [CNT_W-1:0]     xfer_cnt
);

  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             can_load;
  logic             accept;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] last_q,      last_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr (
    .req_i     (bus.in_valid),
    .last_i    (last_q),
    .gnt_idx_o (rr_idx),
    .gnt_vld_o (rr_vld)
  );

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    unique case (mode)
      FIXED: begin
        gnt_idx = sel;
        gnt_vld = {1'b0, sel} < (SEL_W+1)'(NUM_CH);
      end
      ROUND_ROBIN: begin
        gnt_idx = rr_idx;
        gnt_vld = rr_vld;
      end
      default: ;
    endcase
  end

  assign can_load = !out_valid_q || bus.out_ready;

  // rst_n gates ready so nothing is offered while reset is held.
  always_comb begin
    bus.in_ready = '0;
    if (gnt_vld && can_load && rst_n)
      bus.in_ready[gnt_idx] = 1'b1;
  end

  assign accept = |(bus.in_ready & bus.in_valid);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[gnt_idx];
      out_ch_d    = gnt_idx;
      last_d      = gnt_idx;
      cnt_d       = cnt_q + 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= SEL_W'(NUM_CH - 1);
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign xfer_cnt      = cnt_q;

endmodule

// File: doc/stream_selector.md
STREAM_SELECTOR -- requirements
Module: stream_selector

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of input channels, range 2..16.
REQ-002 The block SHALL have parameter WIDTH, default 8: data width per channel, range 1..64.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of the transfer counter.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk: input, 1 bit, rising-edge clock.
REQ-006 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-007 Port mode: input, 1 bit, selection mode (sel_mode_t): 0 = FIXED, 1 = ROUND_ROBIN.
REQ-008 Port sel: input, $clog2(NUM_CH) bits, channel index used in FIXED mode.
REQ-009 Port in_valid: input, NUM_CH bits, per-channel valid.
REQ-010 Port in_data: input, NUM_CH x WIDTH bits, per-channel data (packed array).
REQ-011 Port in_ready: output, NUM_CH bits, per-channel ready; at most one bit is high in any cycle.
REQ-012 Port out_valid: output, 1 bit, output data valid.
REQ-013 Port out_data: output, WIDTH bits, selected data.
REQ-014 Port out_ch: output, $clog2(NUM_CH) bits, source channel of out_data.
REQ-015 Port out_ready: input, 1 bit, downstream ready.
REQ-016 Port xfer_cnt: output, CNT_W bits, count of accepted input transfers.

Function
REQ-017 The block SHALL transfer on channel i in a cycle when in_valid[i] and in_ready[i] are both high; the output transfers when out_valid and out_ready are both high.
REQ-018 The block SHALL assert in_ready[i] only when channel i holds the grant and the output register can load (out_valid low, or out_ready high in the same cycle).
REQ-019 In FIXED mode, the grant SHALL be the channel sel when sel < NUM_CH; when sel >= NUM_CH, no channel is granted.
REQ-020 In ROUND_ROBIN mode, the grant SHALL be the first channel with in_valid high, searching upward from the channel after last_ch and wrapping from NUM_CH-1 to 0.
REQ-021 last_ch SHALL update to the granted index only on an accepted input transfer, in either mode.
REQ-022 Latency SHALL be one cycle: accepted data appears on out_data/out_ch with out_valid high in the next cycle.
REQ-023 The block SHALL sustain full throughput of one transfer per cycle while out_ready stays high.
REQ-024 While out_valid is high and out_ready is low, out_data and out_ch SHALL hold, all in_ready bits SHALL be low, and changes to sel or mode SHALL not affect the held output.
REQ-025 When the output transfers and no input transfer occurs in the same cycle, out_valid SHALL fall in the next cycle.
REQ-026 A change of mode or sel SHALL take effect on the grant in the same cycle, combinationally.
REQ-027 xfer_cnt SHALL increment by 1 on each accepted input transfer and wrap from 2^CNT_W-1 to 0.

Reset
REQ-028 On rst_n low, the block SHALL immediately clear out_valid, out_data, out_ch, xfer_cnt and all in_ready bits to 0.
REQ-029 On rst_n low, the block SHALL set last_ch to NUM_CH-1, so channel 0 has first priority after reset.
REQ-030 Reset asserted mid-stall SHALL discard the held word, with no output transfer occurring.

Structure
REQ-031 Package selector_pkg SHALL define typedef sel_mode_t (FIXED = 0, ROUND_ROBIN = 1).
REQ-032 Package selector_pkg SHALL hold the parameter range limits.
REQ-033 Round-robin grant logic SHALL be a sub-module rr_arbiter with request, last index and grant-index outputs, parametrised by NUM_CH.

Verification
REQ-034 Scenario FIXED single: NUM_CH=4, WIDTH=8, mode=0, sel=2, in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_ch=2, xfer_cnt=1.
REQ-035 Scenario rotation: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3.
REQ-036 Scenario stall: out_valid=1 with out_data=8'h3C and out_ready=0 for 3 cycles, while sel changes -> out_data stays 8'h3C and in_ready=0; on release, out_ready=1 transfers 8'h3C exactly once.
REQ-037 Scenario sparse round-robin: mode=1, in_valid=4'b1001, out_ready=1 -> out_ch alternates 0,3,0,3.
REQ-038 Scenario wrap and reset: CNT_W=4, 16 transfers -> xfer_cnt=0. rst_n pulsed low mid-stall -> all outputs 0 immediately, and the next round-robin grant is channel 0.
